// File: rtl/riscat_rf_pkg.sv
// Shared types and default sizes for the RISCAT integer register file.
// Imported by the register file top and its scoreboard.
package riscat_rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy flop per register.
// A set beats both flush and writeback clear; r0 never goes busy.
module regfile_scoreboard
  import riscat_rf_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NUM_RD = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sb_set_en,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic                 sb_flush,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [NUM_RD*AW-1:0] lk_addr,
  output logic [NUM_RD-1:0]    lk_busy
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (sb_flush)
      busy_nxt = '0;
    else if (wr_en)
      busy_nxt[wr_addr] = 1'b0;
    if (sb_set_en)
      busy_nxt[sb_set_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_lk
    assign lk_busy[p] = busy[lk_addr[p*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with one write port, write-first
// bypass and a pending-write scoreboard for decode hazard checks.
module regfile_mp_sb
  import riscat_rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NUM_RD   = 2,
  parameter int READ_LAT = 0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_RD-1:0]      rd_en,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   sb_set_en,
  input  logic [AW-1:0]          sb_set_addr,
  input  logic                   sb_flush
);

  logic [XLEN-1:0]   regs [1:NREGS-1];
  logic [NUM_RD-1:0] sb_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 1; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk         (clk),
    .reset_n     (reset_n),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_flush    (sb_flush),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .lk_addr     (rd_addr),
    .lk_busy     (sb_busy)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic            set_hit;
    logic [XLEN-1:0] d_c;
    logic            b_c;

    assign a       = rd_addr[p*AW +: AW];
    assign hit     = wr_en && (wr_addr == a);
    assign set_hit = sb_set_en && (sb_set_addr == a);

    // A same-cycle writeback retires the hazard unless it is re-issued.
    always_comb begin
      d_c = '0;
      b_c = 1'b0;
      if (rd_en[p] && (a != '0)) begin
        d_c = hit ? wr_data : regs[a];
        b_c = hit ? set_hit : sb_busy[p];
      end
    end

    if (READ_LAT == 0) begin : g_comb
      assign rd_data[p*XLEN +: XLEN] = d_c;
      assign rd_busy[p]              = b_c;
    end else begin : g_reg
      logic [XLEN-1:0] d_q;
      logic            b_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          d_q <= '0;
          b_q <= 1'b0;
        end else begin
          d_q <= d_c;
          b_q <= b_c;
        end
      end

      assign rd_data[p*XLEN +: XLEN] = d_q;
      assign rd_busy[p]              = b_q;
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Bench for regfile_mp_sb: 4 read ports, 16 x 64-bit, registered read.
// Directed scenarios followed by random traffic against an array model.
module tb_regfile_mp_sb;

  localparam int XLEN = 64;
  localparam int NREGS = 16;
  localparam int NRD = 4;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NRD-1:0]   rd_en;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]   rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [XLEN-1:0]  wr_data;
  logic             sb_set_en;
  logic [AW-1:0]    sb_set_addr;
  logic             sb_flush;

  int checks = 0;
  int failures = 0;

  logic [XLEN-1:0] m_regs [NREGS];
  logic            m_busy [NREGS];
  logic [XLEN-1:0] exp_d [NRD];
  logic            exp_b [NRD];

  always #5 clk = ~clk;

  regfile_mp_sb #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NUM_RD   (NRD),
    .READ_LAT (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_flush    (sb_flush)
  );

  task automatic chk_d(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  function automatic logic [XLEN-1:0] port_d(input int p);
    return rd_data[p*XLEN +: XLEN];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Drive one cycle, predict the sampled reads, advance the model.
  task automatic step(input logic [3:0] en,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                      input logic we, input logic [AW-1:0] wa,
                      input logic [XLEN-1:0] wd,
                      input logic se, input logic [AW-1:0] sa,
                      input logic fl, input string tag);
    logic [AW-1:0] ad [NRD];
    ad[0] = a0; ad[1] = a1; ad[2] = a2; ad[3] = a3;
    rd_en = en;
    rd_addr = {a3, a2, a1, a0};
    wr_en = we; wr_addr = wa; wr_data = wd;
    sb_set_en = se; sb_set_addr = sa; sb_flush = fl;
    for (int p = 0; p < NRD; p++) begin
      exp_d[p] = '0;
      exp_b[p] = 1'b0;
      if (en[p] && ad[p] != 0) begin
        if (we && wa == ad[p]) begin
          exp_d[p] = wd;
          exp_b[p] = se && (sa == ad[p]);
        end else begin
          exp_d[p] = m_regs[ad[p]];
          exp_b[p] = m_busy[ad[p]];
        end
      end
    end
    @(posedge clk);
    if (we && wa != 0) m_regs[wa] = wd;
    if (fl)
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    else if (we) m_busy[wa] = 1'b0;
    if (se && sa != 0) m_busy[sa] = 1'b1;
    #1;
    for (int p = 0; p < NRD; p++) begin
      chk_d($sformatf("%s_d%0d", tag, p), port_d(p), exp_d[p]);
      chk_b($sformatf("%s_b%0d", tag, p), rd_busy[p], exp_b[p]);
    end
  endtask

  task automatic idle(input string tag);
    step(4'h0, 0, 0, 0, 0, 0, 0, '0, 0, 0, 0, tag);
  endtask

  initial begin
    reset_n = 1'b0;
    rd_en = '0; rd_addr = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0;
    sb_set_en = 0; sb_set_addr = '0; sb_flush = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < NRD; p++) begin
      chk_d("rst_d", port_d(p), '0);
      chk_b("rst_b", rd_busy[p], 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-run clears data and busy at once
    step(4'h0, 0, 0, 0, 0, 1, 5, 64'hDEADBEEF, 1, 5, 0, "t1_wr");
    step(4'h3, 5, 5, 0, 0, 0, 0, '0, 0, 0, 0, "t1_rd");
    chk_d("t1_r5", port_d(0), 64'hDEADBEEF);
    chk_b("t1_r5_busy", rd_busy[1], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    for (int p = 0; p < NRD; p++) begin
      chk_d("t1_async_d", port_d(p), '0);
      chk_b("t1_async_b", rd_busy[p], 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(4'h1, 5, 0, 0, 0, 0, 0, '0, 0, 0, 0, "t1_after");
    chk_d("t1_r5_cleared", port_d(0), '0);

    // Plain write then multi-port read, then port 1 disabled
    step(4'h0, 0, 0, 0, 0, 1, 3, 64'h12345678, 0, 0, 0, "t2_wr");
    step(4'h3, 3, 3, 0, 0, 0, 0, '0, 0, 0, 0, "t2_rd");
    chk_d("t2_p0", port_d(0), 64'h12345678);
    chk_d("t2_p1", port_d(1), 64'h12345678);
    step(4'h1, 3, 3, 0, 0, 0, 0, '0, 0, 0, 0, "t2_gate");
    chk_d("t2_p1_gated", port_d(1), '0);

    // r0 stays zero and never busy
    step(4'h0, 0, 0, 0, 0, 1, 0, 64'hFFFFFFFF, 1, 0, 0, "t3_wr");
    step(4'hF, 0, 0, 0, 0, 0, 0, '0, 1, 0, 0, "t3_rd");
    chk_d("t3_r0", port_d(2), '0);
    chk_b("t3_r0_busy", rd_busy[3], 1'b0);

    // Write-first bypass on the same edge
    step(4'h1, 7, 0, 0, 0, 1, 7, 64'hA5A5A5A5, 0, 0, 0, "t4");
    chk_d("t4_bypass", port_d(0), 64'hA5A5A5A5);

    // Set beats same-cycle writeback clear
    step(4'h0, 0, 0, 0, 0, 0, 0, '0, 1, 9, 0, "t5_set");
    step(4'h1, 9, 0, 0, 0, 0, 0, '0, 0, 0, 0, "t5_rd");
    chk_b("t5_busy", rd_busy[0], 1'b1);
    step(4'h2, 0, 9, 0, 0, 1, 9, 64'h99, 1, 9, 0, "t5_wrset");
    chk_b("t5_still_busy", rd_busy[1], 1'b1);
    step(4'h4, 0, 0, 9, 0, 1, 9, 64'h77, 0, 0, 0, "t5_wr");
    chk_b("t5_cleared", rd_busy[2], 1'b0);
    step(4'h8, 0, 0, 0, 9, 0, 0, '0, 0, 0, 0, "t5_after");
    chk_b("t5_after_busy", rd_busy[3], 1'b0);
    chk_d("t5_after_data", port_d(3), 64'h77);

    // Flush with a concurrent set keeps only the new set
    step(4'h0, 0, 0, 0, 0, 0, 0, '0, 1, 4, 0, "t6_s4");
    step(4'h0, 0, 0, 0, 0, 0, 0, '0, 1, 6, 0, "t6_s6");
    step(4'h0, 0, 0, 0, 0, 0, 0, '0, 1, 6, 1, "t6_fl");
    step(4'hF, 4, 6, 6, 4, 0, 0, '0, 0, 0, 0, "t6_rd");
    chk_b("t6_r4", rd_busy[0], 1'b0);
    chk_b("t6_r6", rd_busy[1], 1'b1);
    idle("idle");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           4'($urandom), ($urandom_range(0, 1) == 1), 4'($urandom),
           {$urandom, $urandom}, ($urandom_range(0, 2) == 0),
           4'($urandom), ($urandom_range(0, 19) == 0), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
